// File: rtl/namespace_wb_demux_if.sv
// namespace_wb_demux_if: result stream, the four namespace write ports and the
// status outputs of the SIMD writeback router, bundled as one bus.
// slave  : router side (accepts results, drives namespace writes).
// master : ALU / namespace-memory side.
interface namespace_wb_demux_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  // Result stream from the SIMD ALU output stage
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [2:0]            dest_sel;

  // Namespace write ports
  logic                  obuf_wr_en;
  logic [ADDR_WIDTH-1:0] obuf_wr_addr;
  logic [DATA_WIDTH-1:0] obuf_wr_data;
  logic                  obuf_wr_ready;

  logic                  ibuf_wr_en;
  logic [ADDR_WIDTH-1:0] ibuf_wr_addr;
  logic [DATA_WIDTH-1:0] ibuf_wr_data;
  logic                  ibuf_wr_ready;

  logic                  vmem1_wr_en;
  logic [ADDR_WIDTH-1:0] vmem1_wr_addr;
  logic [DATA_WIDTH-1:0] vmem1_wr_data;
  logic                  vmem1_wr_ready;

  logic                  vmem2_wr_en;
  logic [ADDR_WIDTH-1:0] vmem2_wr_addr;
  logic [DATA_WIDTH-1:0] vmem2_wr_data;
  logic                  vmem2_wr_ready;

  // Status
  logic                  illegal_dest;
  logic [15:0]           wb_count;

  modport slave (
    input  in_valid, in_data, in_addr, dest_sel,
    input  obuf_wr_ready, ibuf_wr_ready, vmem1_wr_ready, vmem2_wr_ready,
    output in_ready,
    output obuf_wr_en, obuf_wr_addr, obuf_wr_data,
    output ibuf_wr_en, ibuf_wr_addr, ibuf_wr_data,
    output vmem1_wr_en, vmem1_wr_addr, vmem1_wr_data,
    output vmem2_wr_en, vmem2_wr_addr, vmem2_wr_data,
    output illegal_dest, wb_count
  );

  modport master (
    output in_valid, in_data, in_addr, dest_sel,
    output obuf_wr_ready, ibuf_wr_ready, vmem1_wr_ready, vmem2_wr_ready,
    input  in_ready,
    input  obuf_wr_en, obuf_wr_addr, obuf_wr_data,
    input  ibuf_wr_en, ibuf_wr_addr, ibuf_wr_data,
    input  vmem1_wr_en, vmem1_wr_addr, vmem1_wr_data,
    input  vmem2_wr_en, vmem2_wr_addr, vmem2_wr_data,
    input  illegal_dest, wb_count
  );
endinterface

// File: rtl/namespace_wb_demux.sv
// namespace_wb_demux: SIMD writeback router. Buffers ALU results in a 2-entry
// in-order FIFO and presents the head entry on the write port of its
// destination namespace (OBUF, IBUF, VMEM1, VMEM2) until that namespace
// accepts it. Write outputs depend on registered state only.
//
// Optional feature macro: SIMD_WB_ILLEGAL_CHECK_EN
//   defined   : dest codes 1xx are dropped without a write and flag the
//               sticky illegal_dest output.
//   undefined : dest codes 1xx are written to OBUF; illegal_dest is 0.
//
// The DATA_WIDTH / ADDR_WIDTH parameters must match those of the bus.
module namespace_wb_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  namespace_wb_demux_if.slave   bus
);

  typedef enum logic [1:0] {
    NS_OBUF  = 2'd0,
    NS_IBUF  = 2'd1,
    NS_VMEM1 = 2'd2,
    NS_VMEM2 = 2'd3
  } ns_e;

  typedef struct packed {
    logic [2:0]            dest;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t      fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [15:0] wb_count_q;

  entry_t      head;
  logic        head_valid;
  logic        head_drop;
  ns_e         head_ns;
  logic        ns_ready;
  logic        push;
  logic        pop;
  logic        wb_done;

  assign head       = fifo_mem[rd_ptr];
  // The reset term keeps every write strobe low while reset is held, so a
  // buffered entry is never written during the reset cycle.
  assign head_valid = ~reset & (count != 2'd0);
  assign bus.in_ready = ~reset & (count != 2'd2);

  // Resolve the head entry's destination namespace and whether it is dropped
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    head_drop = 1'b0;
    head_ns   = ns_e'(head.dest[1:0]);
`ifdef SIMD_WB_ILLEGAL_CHECK_EN
    head_drop = head.dest[2];
`else
    if (head.dest[2]) head_ns = NS_OBUF;
`endif
  end

  // Select the ready of the namespace the head is waiting on
  always_comb begin
    ns_ready = 1'b0;
    case (head_ns)
      NS_OBUF:  ns_ready = bus.obuf_wr_ready;
      NS_IBUF:  ns_ready = bus.ibuf_wr_ready;
      NS_VMEM1: ns_ready = bus.vmem1_wr_ready;
      NS_VMEM2: ns_ready = bus.vmem2_wr_ready;
      default:  ns_ready = 1'b0;
    endcase
  end

  // A full buffer never accepts, even when the head pops in the same cycle.
  assign push    = bus.in_valid & bus.in_ready;
  assign wb_done = head_valid & ~head_drop & ns_ready;
  assign pop     = wb_done | (head_valid & head_drop);

  // Drive the head entry onto its namespace port; idle ports read as zero
  always_comb begin
    bus.obuf_wr_en     = 1'b0;
    bus.obuf_wr_addr   = '0;
    bus.obuf_wr_data   = '0;
    bus.ibuf_wr_en     = 1'b0;
    bus.ibuf_wr_addr   = '0;
    bus.ibuf_wr_data   = '0;
    bus.vmem1_wr_en    = 1'b0;
    bus.vmem1_wr_addr  = '0;
    bus.vmem1_wr_data  = '0;
    bus.vmem2_wr_en    = 1'b0;
    bus.vmem2_wr_addr  = '0;
    bus.vmem2_wr_data  = '0;
    if (head_valid && !head_drop) begin
      case (head_ns)
        NS_OBUF: begin
          bus.obuf_wr_en   = 1'b1;
          bus.obuf_wr_addr = head.addr;
          bus.obuf_wr_data = head.data;
        end
        NS_IBUF: begin
          bus.ibuf_wr_en   = 1'b1;
          bus.ibuf_wr_addr = head.addr;
          bus.ibuf_wr_data = head.data;
        end
        NS_VMEM1: begin
          bus.vmem1_wr_en   = 1'b1;
          bus.vmem1_wr_addr = head.addr;
          bus.vmem1_wr_data = head.data;
        end
        NS_VMEM2: begin
          bus.vmem2_wr_en   = 1'b1;
          bus.vmem2_wr_addr = head.addr;
          bus.vmem2_wr_data = head.data;
        end
        default: ;
      endcase
    end
  end

  // Buffer storage: written on push only
  // NOTE: the data array carries no reset; occupancy (count) alone decides
  // which entries are meaningful, so clearing the payload would buy nothing.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{dest: bus.dest_sel, addr: bus.in_addr, data: bus.in_data};
  end

  // Pointers, occupancy and completed-write counter
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      wb_count_q <= 16'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (wb_done) wb_count_q <= wb_count_q + 16'd1;
    end
  end

  assign bus.wb_count = wb_count_q;

`ifdef SIMD_WB_ILLEGAL_CHECK_EN
  logic illegal_q;

  // Sticky flag set when an illegal destination is dropped from the head
  always_ff @(posedge clk) begin
    if (reset)                       illegal_q <= 1'b0;
    else if (head_valid && head_drop) illegal_q <= 1'b1;
  end

  assign bus.illegal_dest = illegal_q;
`else
  assign bus.illegal_dest = 1'b0;
`endif

endmodule

// File: tb/tb_namespace_wb_demux.sv
// tb_namespace_wb_demux: randomized and directed stimulus for the SIMD
// writeback router, checked every cycle against a queue-based reference model.
// Build with or without SIMD_WB_ILLEGAL_CHECK_EN; expectations follow the macro.
module tb_namespace_wb_demux;
  localparam int DW = 32;
  localparam int AW = 10;
`ifdef SIMD_WB_ILLEGAL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  namespace_wb_demux_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  namespace_wb_demux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ordered list of accepted results plus the two status values
  typedef struct {
    logic [2:0]    dest;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_wb  = 16'd0;
  bit          m_ill = 1'b0;
  bit          last_push;

  string ns_name [4] = '{"obuf", "ibuf", "vmem1", "vmem2"};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Namespace a destination code writes to, or -1 when it is dropped
  function automatic int target(input logic [2:0] d);
    if (d >= 3'd4) return CHK_EN ? -1 : 0;
    return int'(d);
  endfunction

  task automatic check_outputs();
    logic          exp_en   [4];
    logic [AW-1:0] exp_addr [4];
    logic [DW-1:0] exp_data [4];
    logic          got_en   [4];
    logic [AW-1:0] got_addr [4];
    logic [DW-1:0] got_data [4];
    for (int i = 0; i < 4; i++) begin
      exp_en[i] = 1'b0; exp_addr[i] = '0; exp_data[i] = '0;
    end
    if (!reset && q.size() > 0) begin
      int t = target(q[0].dest);
      if (t >= 0) begin
        exp_en[t] = 1'b1; exp_addr[t] = q[0].addr; exp_data[t] = q[0].data;
      end
    end
    got_en   = '{bus.obuf_wr_en,   bus.ibuf_wr_en,   bus.vmem1_wr_en,   bus.vmem2_wr_en};
    got_addr = '{bus.obuf_wr_addr, bus.ibuf_wr_addr, bus.vmem1_wr_addr, bus.vmem2_wr_addr};
    got_data = '{bus.obuf_wr_data, bus.ibuf_wr_data, bus.vmem1_wr_data, bus.vmem2_wr_data};
    for (int i = 0; i < 4; i++) begin
      check({ns_name[i], "_wr_en"},   64'(got_en[i]),   64'(exp_en[i]));
      check({ns_name[i], "_wr_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
      check({ns_name[i], "_wr_data"}, 64'(got_data[i]), 64'(exp_data[i]));
    end
    check("in_ready",     64'(bus.in_ready),     64'(!reset && q.size() < 2));
    check("wb_count",     64'(bus.wb_count),     64'(m_wb));
    check("illegal_dest", 64'(bus.illegal_dest), 64'(m_ill));
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model by what the next rising edge will do.
  task automatic step(input bit v, input logic [2:0] d, input logic [AW-1:0] a,
                      input logic [DW-1:0] dat, input logic [3:0] rdy, input bit rst);
    bit do_push, do_pop;
    int t;
    @(negedge clk);
    reset              = rst;
    bus.in_valid       = v;
    bus.dest_sel       = d;
    bus.in_addr        = a;
    bus.in_data        = dat;
    bus.obuf_wr_ready  = rdy[0];
    bus.ibuf_wr_ready  = rdy[1];
    bus.vmem1_wr_ready = rdy[2];
    bus.vmem2_wr_ready = rdy[3];
    #1;
    check_outputs();
    last_push = 1'b0;
    if (rst) begin
      q.delete();
      m_wb  = 16'd0;
      m_ill = 1'b0;
    end else begin
      do_push = v && (q.size() < 2);
      do_pop  = 1'b0;
      if (q.size() > 0) begin
        t = target(q[0].dest);
        if (t < 0) begin
          do_pop = 1'b1;
          m_ill  = 1'b1;
        end else if (rdy[t]) begin
          do_pop = 1'b1;
          m_wb   = m_wb + 16'd1;
        end
      end
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{dest: d, addr: a, data: dat});
      last_push = do_push;
    end
  endtask

  task automatic idle(input int n, input logic [3:0] rdy);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, '0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 3'd0, '0, '0, 4'hF, 1'b1);
  endtask

  // Source holds a result until it is accepted (bounded)
  task automatic push_hold(input logic [2:0] d, input logic [AW-1:0] a,
                           input logic [DW-1:0] dat, input logic [3:0] rdy);
    int tries = 0;
    do begin
      step(1'b1, d, a, dat, rdy, 1'b0);
      tries++;
    end while (!last_push && tries < 50);
    check("push_accepted", 64'(last_push), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.dest_sel = '0; bus.in_addr = '0; bus.in_data = '0;
    bus.obuf_wr_ready = 1'b1; bus.ibuf_wr_ready = 1'b1;
    bus.vmem1_wr_ready = 1'b1; bus.vmem2_wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();
    idle(1, 4'hF);
    check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Back-to-back to each namespace
    for (int i = 0; i < 4; i++)
      step(1'b1, 3'(i), AW'(5 + i), DW'(32'hA0 + i), 4'hF, 1'b0);
    idle(2, 4'hF);
    check("b2b_wb_count", 64'(bus.wb_count), 64'd4);

    // Stall / full on VMEM1
    do_reset();
    push_hold(3'd2, AW'(10), DW'(32'h11), 4'b1011);
    push_hold(3'd2, AW'(11), DW'(32'h22), 4'b1011);
    for (int i = 0; i < 4; i++) step(1'b1, 3'd2, AW'(12), DW'(32'h33), 4'b1011, 1'b0);
    check("full_vmem1_addr", 64'(bus.vmem1_wr_addr), 64'd10);
    push_hold(3'd2, AW'(12), DW'(32'h33), 4'hF);
    idle(3, 4'hF);
    check("stall_wb_count", 64'(bus.wb_count), 64'd3);

    // Head-of-line: OBUF stalled, IBUF behind it
    do_reset();
    push_hold(3'd0, AW'(1), DW'(32'hB0), 4'b1110);
    push_hold(3'd1, AW'(2), DW'(32'hB1), 4'b1110);
    idle(5, 4'b1110);
    idle(3, 4'hF);

    // Illegal destination
    do_reset();
    push_hold(3'd4, AW'(3), DW'(32'h55), 4'hF);
    idle(3, 4'hF);
    check("illegal_flag", 64'(bus.illegal_dest), 64'(CHK_EN));
    check("illegal_wb_count", 64'(bus.wb_count), 64'(CHK_EN ? 0 : 1));

    // Reset with two entries buffered and stalled
    do_reset();
    push_hold(3'd3, AW'(7), DW'(32'hC0), 4'h0);
    push_hold(3'd1, AW'(8), DW'(32'hC1), 4'h0);
    do_reset();
    idle(3, 4'hF);
    check("reset_mid_wb_count", 64'(bus.wb_count), 64'd0);

    // Counter wrap: 65536 completed writes
    do_reset();
    for (int i = 0; i < 65536; i++)
      step(1'b1, 3'($urandom_range(0, 3)), AW'($urandom), DW'($urandom), 4'hF, 1'b0);
    idle(2, 4'hF);
    check("wrap_wb_count", 64'(bus.wb_count), 64'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 70, 3'($urandom_range(0, 7)), AW'($urandom),
           DW'($urandom), 4'($urandom), $urandom_range(0, 199) == 0);
    idle(4, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
